// File: rtl/button_event.sv
// Classifies a debounced button level into press/release/click/double-click/
// long-press/auto-repeat strobes; all outputs registered, timing in clk cycles.
module button_event #(
    parameter int unsigned NBITS        = 24,
    parameter int unsigned LONG_TICKS   = 9375000,
    parameter int unsigned DOUBLE_TICKS = 7500000,
    parameter int unsigned REPEAT_TICKS = 3750000
) (
    input  logic clk,
    input  logic reset,
    input  logic clean,
    output logic held,
    output logic press,
    output logic release_evt,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_evt
);

    // Timeouts fire on the last count value of the interval (N-1).
    localparam logic [NBITS-1:0] LONG_LAST   = NBITS'(LONG_TICKS - 1);
    localparam logic [NBITS-1:0] DOUBLE_LAST = NBITS'(DOUBLE_TICKS - 1);
    localparam logic [NBITS-1:0] REPEAT_LAST =
        (REPEAT_TICKS == 0) ? '0 : NBITS'(REPEAT_TICKS - 1);
    localparam bit REPEAT_EN = (REPEAT_TICKS != 0);

    typedef enum logic [2:0] {
        LOCKOUT  = 3'd0,
        IDLE     = 3'd1,
        PRESSED  = 3'd2,
        LONG     = 3'd3,
        WAIT2    = 3'd4,
        PRESSED2 = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] count;
    logic [NBITS-1:0] count_next;
    logic             count_clr;
    logic             timed;
    logic             press_d;
    logic             release_d;
    logic             single_d;
    logic             double_d;
    logic             long_d;
    logic             repeat_d;

    // Next-state, strobe and interval-counter decode.
    always_comb begin
        state_next = state;
        count_clr  = 1'b0;
        press_d    = 1'b0;
        release_d  = 1'b0;
        single_d   = 1'b0;
        double_d   = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        count_next = count;

        case (state)
            LOCKOUT: begin
                if (!clean) state_next = IDLE;
            end
            IDLE: begin
                if (clean) begin
                    state_next = PRESSED;
                    press_d    = 1'b1;
                end
            end
            PRESSED: begin
                // Release takes precedence over a coincident long-press timeout.
                if (!clean) begin
                    state_next = WAIT2;
                    release_d  = 1'b1;
                end else if (count == LONG_LAST) begin
                    state_next = LONG;
                    long_d     = 1'b1;
                end
            end
            LONG: begin
                if (!clean) begin
                    state_next = IDLE;
                    release_d  = 1'b1;
                end else if (REPEAT_EN && (count == REPEAT_LAST)) begin
                    repeat_d  = 1'b1;
                    count_clr = 1'b1;
                end
            end
            WAIT2: begin
                // A second press on the final window cycle still counts as double.
                if (clean) begin
                    state_next = PRESSED2;
                    press_d    = 1'b1;
                    double_d   = 1'b1;
                end else if (count == DOUBLE_LAST) begin
                    state_next = IDLE;
                    single_d   = 1'b1;
                end
            end
            PRESSED2: begin
                if (!clean) begin
                    state_next = IDLE;
                    release_d  = 1'b1;
                end
            end
            default: begin
                state_next = LOCKOUT;
            end
        endcase

        timed = (state == PRESSED) || (state == LONG) || (state == WAIT2);

        if (count_clr || (state_next != state)) begin
            count_next = '0;
        end else if (timed && (count != '1)) begin
            count_next = count + NBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOCKOUT;
            count        <= '0;
            held         <= 1'b0;
            press        <= 1'b0;
            release_evt  <= 1'b0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_evt   <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            held         <= clean;
            press        <= press_d;
            release_evt  <= release_d;
            single_click <= single_d;
            double_click <= double_d;
            long_press   <= long_d;
            repeat_evt   <= repeat_d;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: segment table plus expected-event table,
// checked every cycle, followed by a hand-written reset-in-WAIT2 sequence.
module tb_button_event;

    logic clk;
    logic reset;
    logic clean;
    logic held;
    logic press;
    logic release_evt;
    logic single_click;
    logic double_click;
    logic long_press;
    logic repeat_evt;

    button_event #(
        .NBITS       (8),
        .LONG_TICKS  (20),
        .DOUBLE_TICKS(10),
        .REPEAT_TICKS(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clean       (clean),
        .held        (held),
        .press       (press),
        .release_evt (release_evt),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_evt  (repeat_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: {press, release, single, double, long, repeat}
    localparam logic [5:0] EV_P  = 6'b100000;
    localparam logic [5:0] EV_R  = 6'b010000;
    localparam logic [5:0] EV_S  = 6'b001000;
    localparam logic [5:0] EV_D  = 6'b000100;
    localparam logic [5:0] EV_L  = 6'b000010;
    localparam logic [5:0] EV_RP = 6'b000001;

    typedef struct {
        logic rst;
        logic cln;
        int   n;
    } seg_t;

    typedef struct {
        int         t;
        logic [5:0] ev;
    } evt_t;

    seg_t segs[$];
    evt_t evts[$];
    int   total;
    int   bad;
    int   t;

    function automatic logic [5:0] exp_at(input int tt);
        logic [5:0] e;
        e = '0;
        foreach (evts[i]) begin
            if (evts[i].t == tt) e = evts[i].ev;
        end
        return e;
    endfunction

    // Drive one cycle, then check held and the strobe vector after the edge.
    task automatic step(input logic r, input logic c, input logic [5:0] exp_ev, input string name);
        logic [5:0] got;
        logic       exp_held;
        reset = r;
        clean = c;
        @(posedge clk);
        #1;
        exp_held = r ? 1'b0 : c;
        got = {press, release_evt, single_click, double_click, long_press, repeat_evt};
        total++;
        if (held !== exp_held) begin
            bad++;
            $display("FAIL %s held t=%0d got=%b want=%b", name, t, held, exp_held);
        end
        total++;
        if (got !== exp_ev) begin
            bad++;
            $display("FAIL %s strobes t=%0d got=%b want=%b", name, t, got, exp_ev);
        end
        t++;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        t     = 0;
        reset = 1'b1;
        clean = 1'b1;

        // 1: reset with button held, lockout, then a short click
        segs.push_back('{1'b1, 1'b1, 3});
        segs.push_back('{1'b0, 1'b1, 30});
        segs.push_back('{1'b0, 1'b0, 30});
        segs.push_back('{1'b0, 1'b1, 5});
        segs.push_back('{1'b0, 1'b0, 15});
        // 2: double click
        segs.push_back('{1'b0, 1'b1, 5});
        segs.push_back('{1'b0, 1'b0, 4});
        segs.push_back('{1'b0, 1'b1, 5});
        segs.push_back('{1'b0, 1'b0, 15});
        // 3: long press with auto-repeat
        segs.push_back('{1'b0, 1'b1, 36});
        segs.push_back('{1'b0, 1'b0, 15});
        // 4: release coincides with long-press timeout
        segs.push_back('{1'b0, 1'b1, 20});
        segs.push_back('{1'b0, 1'b0, 20});
        // 5: second press on the window's last cycle, then a long PRESSED2 hold
        segs.push_back('{1'b0, 1'b1, 3});
        segs.push_back('{1'b0, 1'b0, 10});
        segs.push_back('{1'b0, 1'b1, 30});
        segs.push_back('{1'b0, 1'b0, 12});
        // 6: reset during LONG, lockout, then a fresh click
        segs.push_back('{1'b0, 1'b1, 25});
        segs.push_back('{1'b1, 1'b1, 1});
        segs.push_back('{1'b0, 1'b1, 10});
        segs.push_back('{1'b0, 1'b0, 3});
        segs.push_back('{1'b0, 1'b1, 3});
        segs.push_back('{1'b0, 1'b0, 15});

        evts.push_back('{63,  EV_P});
        evts.push_back('{68,  EV_R});
        evts.push_back('{78,  EV_S});
        evts.push_back('{83,  EV_P});
        evts.push_back('{88,  EV_R});
        evts.push_back('{92,  EV_P | EV_D});
        evts.push_back('{97,  EV_R});
        evts.push_back('{112, EV_P});
        evts.push_back('{132, EV_L});
        evts.push_back('{137, EV_RP});
        evts.push_back('{142, EV_RP});
        evts.push_back('{147, EV_RP});
        evts.push_back('{148, EV_R});
        evts.push_back('{163, EV_P});
        evts.push_back('{183, EV_R});
        evts.push_back('{193, EV_S});
        evts.push_back('{203, EV_P});
        evts.push_back('{206, EV_R});
        evts.push_back('{216, EV_P | EV_D});
        evts.push_back('{246, EV_R});
        evts.push_back('{258, EV_P});
        evts.push_back('{278, EV_L});
        evts.push_back('{297, EV_P});
        evts.push_back('{300, EV_R});
        evts.push_back('{310, EV_S});

        foreach (segs[s]) begin
            for (int k = 0; k < segs[s].n; k++) begin
                step(segs[s].rst, segs[s].cln, exp_at(t), $sformatf("seg%0d", s));
            end
        end

        // Reset aborts a pending single click in WAIT2; then a fresh press.
        step(1'b0, 1'b1, EV_P, "abort_press");
        step(1'b0, 1'b1, 6'b0, "abort_hold");
        step(1'b0, 1'b0, EV_R, "abort_rel");
        step(1'b0, 1'b0, 6'b0, "abort_wait");
        step(1'b0, 1'b0, 6'b0, "abort_wait");
        step(1'b1, 1'b0, 6'b0, "abort_reset");
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0, 6'b0, "abort_quiet");
        end
        step(1'b0, 1'b1, EV_P, "abort_repress");
        step(1'b0, 1'b0, EV_R, "abort_rerel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
